// File: rtl/contador_ud_ctrl_pkg.sv
// Shared types and defaults for the bounded up/down counter sequencer.
package contador_pkg;

   localparam int WIDTH_DEF   = 4;
   localparam int PRESC_W_DEF = 8;

   typedef enum logic [1:0] {
      UP_ONCE    = 2'd0,
      DOWN_ONCE  = 2'd1,
      PINGPONG   = 2'd2,
      PINGPONG_N = 2'd3
   } mode_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      UP   = 2'd1,
      DOWN = 2'd2,
      DONE = 2'd3
   } state_t;

   // A round-trip request of zero still runs one full trip.
   function automatic logic [3:0] alvo_ciclos(input logic [3:0] ciclos);
      return (ciclos == 4'd0) ? 4'd1 : ciclos;
   endfunction

endpackage

// File: rtl/contador_ud_ctrl_if.sv
// Command/status bundle between the control logic (master) and the counter sequencer (slave).
interface contador_ud_ctrl_if #(
   parameter int WIDTH   = 4,
   parameter int PRESC_W = 8
) ();

   logic               start;
   logic               stop;
   logic [1:0]         mode;
   logic [WIDTH-1:0]   lim_lo;
   logic [WIDTH-1:0]   lim_hi;
   logic [PRESC_W-1:0] presc;
   logic [3:0]         ciclos;
   logic [WIDTH-1:0]   saida;
   logic               direcao;
   logic               busy;
   logic               done;
   logic               erro;

   modport master (
      output start, stop, mode, lim_lo, lim_hi, presc, ciclos,
      input  saida, direcao, busy, done, erro
   );

   modport slave (
      input  start, stop, mode, lim_lo, lim_hi, presc, ciclos,
      output saida, direcao, busy, done, erro
   );

endinterface

// File: rtl/contador_ud_ctrl_gerador_tick.sv
// Step prescaler: tick fires when the count reaches the period, then the count restarts at zero.
module gerador_tick #(
   parameter int PRESC_W = 8
) (
   input  logic               clock,
   input  logic               resert,
   input  logic               clr,
   input  logic               en,
   input  logic [PRESC_W-1:0] periodo,
   output logic               tick
);

   localparam logic [PRESC_W-1:0] UM = {{(PRESC_W-1){1'b0}}, 1'b1};

   logic [PRESC_W-1:0] cnt_r;
   logic [PRESC_W-1:0] cnt_s;

   assign tick = en && (cnt_r == periodo);

   // Next prescaler count: clear wins, otherwise wrap on tick or advance while enabled.
   always_comb begin
      cnt_s = cnt_r;
      if (clr) begin
         cnt_s = '0;
      end else if (en) begin
         if (tick) begin
            cnt_s = '0;
         end else begin
            cnt_s = cnt_r + UM;
         end
      end else begin
         cnt_s = cnt_r;
      end
   end

   // Prescaler count register.
   always_ff @(posedge clock or posedge resert) begin
      if (resert) begin
         cnt_r <= '0;
      end else begin
         cnt_r <= cnt_s;
      end
   end

endmodule

// File: rtl/contador_ud_ctrl.sv
// Bounded up/down counter sequencer: single or ping-pong sweeps between shadowed limits,
// one step per prescaler tick, with a one-step dwell at each turning point.
module contador_ud_ctrl
   import contador_pkg::*;
#(
   parameter int WIDTH   = WIDTH_DEF,
   parameter int PRESC_W = PRESC_W_DEF
) (
   input  logic              clock,
   input  logic              resert,
   contador_ud_ctrl_if.slave bus
);

   localparam logic [WIDTH-1:0] UM = {{(WIDTH-1){1'b0}}, 1'b1};

   state_t             state_r,  state_s;
   mode_t              mode_r,   mode_s;
   logic [WIDTH-1:0]   lo_r,     lo_s;
   logic [WIDTH-1:0]   hi_r,     hi_s;
   logic [PRESC_W-1:0] presc_r,  presc_s;
   logic [3:0]         ciclos_r, ciclos_s;
   logic [3:0]         rt_r,     rt_s;
   logic [WIDTH-1:0]   saida_r,  saida_s;
   logic               dir_r,    dir_s;
   logic               busy_r,   busy_s;
   logic               done_r,   done_s;
   logic               erro_r,   erro_s;
   logic               tick_s;
   logic               clr_s;

   // The prescaler only runs while sweeping, so every load starts it from zero.
   assign clr_s = (state_r != UP) && (state_r != DOWN);

   gerador_tick #(.PRESC_W(PRESC_W)) u_tick (
      .clock   (clock),
      .resert  (resert),
      .clr     (clr_s),
      .en      (!clr_s),
      .periodo (presc_r),
      .tick    (tick_s)
   );

   // Next-state, shadow and datapath decisions; stop outranks a coincident tick.
   always_comb begin
      state_s  = state_r;
      mode_s   = mode_r;
      lo_s     = lo_r;
      hi_s     = hi_r;
      presc_s  = presc_r;
      ciclos_s = ciclos_r;
      rt_s     = rt_r;
      saida_s  = saida_r;
      dir_s    = dir_r;
      busy_s   = busy_r;
      done_s   = 1'b0;
      erro_s   = erro_r;
      case (state_r)
         IDLE: begin
            if (bus.start) begin
               if (bus.lim_lo > bus.lim_hi) begin
                  erro_s = 1'b1;
               end else begin
                  mode_s   = mode_t'(bus.mode);
                  lo_s     = bus.lim_lo;
                  hi_s     = bus.lim_hi;
                  presc_s  = bus.presc;
                  ciclos_s = bus.ciclos;
                  rt_s     = 4'd0;
                  erro_s   = 1'b0;
                  busy_s   = 1'b1;
                  if (mode_t'(bus.mode) == DOWN_ONCE) begin
                     saida_s = bus.lim_hi;
                     dir_s   = 1'b1;
                     state_s = DOWN;
                  end else begin
                     saida_s = bus.lim_lo;
                     dir_s   = 1'b0;
                     state_s = UP;
                  end
               end
            end else begin
               state_s = IDLE;
            end
         end
         UP: begin
            if (bus.stop) begin
               state_s = IDLE;
               busy_s  = 1'b0;
            end else if (tick_s) begin
               if (saida_r < hi_r) begin
                  saida_s = saida_r + UM;
               end else if (mode_r == UP_ONCE) begin
                  state_s = DONE;
                  busy_s  = 1'b0;
                  done_s  = 1'b1;
               end else begin
                  dir_s   = 1'b1;
                  state_s = DOWN;
               end
            end else begin
               state_s = UP;
            end
         end
         DOWN: begin
            if (bus.stop) begin
               state_s = IDLE;
               busy_s  = 1'b0;
            end else if (tick_s) begin
               if (saida_r > lo_r) begin
                  saida_s = saida_r - UM;
               end else begin
                  case (mode_r)
                     PINGPONG: begin
                        dir_s   = 1'b0;
                        state_s = UP;
                     end
                     PINGPONG_N: begin
                        rt_s = rt_r + 4'd1;
                        if (rt_s == alvo_ciclos(ciclos_r)) begin
                           state_s = DONE;
                           busy_s  = 1'b0;
                           done_s  = 1'b1;
                        end else begin
                           dir_s   = 1'b0;
                           state_s = UP;
                        end
                     end
                     default: begin
                        state_s = DONE;
                        busy_s  = 1'b0;
                        done_s  = 1'b1;
                     end
                  endcase
               end
            end else begin
               state_s = DOWN;
            end
         end
         DONE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
            busy_s  = 1'b0;
         end
      endcase
   end

   // State, shadow configuration and output registers.
   always_ff @(posedge clock or posedge resert) begin
      if (resert) begin
         state_r  <= IDLE;
         mode_r   <= UP_ONCE;
         lo_r     <= '0;
         hi_r     <= '0;
         presc_r  <= '0;
         ciclos_r <= 4'd0;
         rt_r     <= 4'd0;
         saida_r  <= '0;
         dir_r    <= 1'b0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         erro_r   <= 1'b0;
      end else begin
         state_r  <= state_s;
         mode_r   <= mode_s;
         lo_r     <= lo_s;
         hi_r     <= hi_s;
         presc_r  <= presc_s;
         ciclos_r <= ciclos_s;
         rt_r     <= rt_s;
         saida_r  <= saida_s;
         dir_r    <= dir_s;
         busy_r   <= busy_s;
         done_r   <= done_s;
         erro_r   <= erro_s;
      end
   end

   assign bus.saida   = saida_r;
   assign bus.direcao = dir_r;
   assign bus.busy    = busy_r;
   assign bus.done    = done_r;
   assign bus.erro    = erro_r;

endmodule
